// File: rtl/i2s_tdm_deframer_pkg.sv
// Shared types and helpers for the I2S/TDM deframer: lock FSM states,
// default frame geometry and stereo slot-index decoding.
package i2s_tdm_deframer_pkg;

    localparam int DEF_SLOT_WIDTH = 32;
    localparam int DEF_NUM_SLOTS  = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNCING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Slot index is at least one bit wide, even for a single-slot frame
    function automatic int slot_idx_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    function automatic int unsigned slot_pair(input int unsigned slot);
        return slot >> 1;
    endfunction

    function automatic logic slot_lr(input int unsigned slot);
        return slot[0];
    endfunction

endpackage

// File: rtl/i2s_tdm_deframer_if.sv
// Serial TDM input and deframed sample output bundle; master is the deframer.
interface i2s_tdm_deframer_if
    import i2s_tdm_deframer_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS
);
    localparam int SLOT_IDX_W = slot_idx_width(NUM_SLOTS);

    logic                  i2s_fsync;
    logic                  i2s_data;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [SLOT_IDX_W-1:0] sample_slot;
    logic                  sample_valid;
    logic                  sample_toggle;
    logic                  locked;
    logic                  sync_err;

    modport master (
        input  i2s_fsync, i2s_data,
        output sample_data, sample_slot, sample_valid, sample_toggle, locked, sync_err
    );

    modport slave (
        output i2s_fsync, i2s_data,
        input  sample_data, sample_slot, sample_valid, sample_toggle, locked, sync_err
    );

endinterface

// File: rtl/i2s_tdm_deframer.sv
// I2S/TDM deframer: aligns to fsync with one-bit delay, checks frame length,
// and delivers MSB-aligned slot payloads once LOCK_FRAMES good frames are seen.
module i2s_tdm_deframer
    import i2s_tdm_deframer_pkg::*;
#(
    parameter int SLOT_WIDTH  = DEF_SLOT_WIDTH,
    parameter int DATA_WIDTH  = 24,
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int LOCK_FRAMES = 2
)(
    input  logic i2s_bclk,
    input  logic sys_rst,
    i2s_tdm_deframer_if.master bus
);
    localparam int FRAME_BITS = NUM_SLOTS * SLOT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int SLOT_W     = slot_idx_width(NUM_SLOTS);
    localparam int GOOD_W     = $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_W-1:0]  FRAME_FULL  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  FRAME_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  SLOT_BITS   = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0]  SLOT_LAST   = CNT_W'(SLOT_WIDTH - 1);
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_FRAMES - 1);

    state_t                state_reg;
    logic                  fsync_d_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [GOOD_W-1:0]     good_cnt_reg;
    logic [SLOT_WIDTH-1:0] shift_reg;
    logic                  deliver_pend_reg;
    logic [SLOT_W-1:0]     pend_slot_reg;
    logic [DATA_WIDTH-1:0] sample_data_reg;
    logic [SLOT_W-1:0]     sample_slot_reg;
    logic                  sample_valid_reg;
    logic                  sample_toggle_reg;
    logic                  locked_reg;
    logic                  sync_err_reg;

    logic frame_edge;
    logic frame_full_now;
    logic frame_bad;
    logic slot_end;

    // bit_cnt_reg counts bits already sampled; the bit arriving now is number
    // bit_cnt_reg+1, so FRAME_LAST means this bit completes the frame.
    always_comb begin
        frame_edge     = bus.i2s_fsync & ~fsync_d_reg;
        frame_full_now = (bit_cnt_reg == FRAME_LAST);
        frame_bad      = frame_edge ^ frame_full_now;
        slot_end       = (bit_cnt_reg < FRAME_FULL) && ((bit_cnt_reg % SLOT_BITS) == SLOT_LAST);
    end

    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg         <= ST_UNLOCKED;
            fsync_d_reg       <= 1'b0;
            bit_cnt_reg       <= '0;
            good_cnt_reg      <= '0;
            shift_reg         <= '0;
            deliver_pend_reg  <= 1'b0;
            pend_slot_reg     <= '0;
            sample_data_reg   <= '0;
            sample_slot_reg   <= '0;
            sample_valid_reg  <= 1'b0;
            sample_toggle_reg <= 1'b0;
            locked_reg        <= 1'b0;
            sync_err_reg      <= 1'b0;
        end else begin
            fsync_d_reg      <= bus.i2s_fsync;
            shift_reg        <= {shift_reg[SLOT_WIDTH-2:0], bus.i2s_data};
            sample_valid_reg <= 1'b0;
            sync_err_reg     <= 1'b0;
            deliver_pend_reg <= 1'b0;

            if (frame_edge)
                bit_cnt_reg <= '0;
            else if (bit_cnt_reg != FRAME_FULL)
                bit_cnt_reg <= bit_cnt_reg + 1'b1;

            // Shift register holds the complete slot one edge after its LSB
            if (deliver_pend_reg) begin
                sample_data_reg   <= shift_reg[SLOT_WIDTH-1 -: DATA_WIDTH];
                sample_slot_reg   <= pend_slot_reg;
                sample_valid_reg  <= 1'b1;
                sample_toggle_reg <= ~sample_toggle_reg;
            end

            case (state_reg)
                ST_UNLOCKED: begin
                    if (frame_edge) begin
                        state_reg    <= ST_SYNCING;
                        good_cnt_reg <= '0;
                    end
                end
                ST_SYNCING: begin
                    if (frame_edge) begin
                        if (!frame_full_now) begin
                            good_cnt_reg <= '0;
                        end else if (good_cnt_reg == LOCK_LAST) begin
                            state_reg    <= ST_LOCKED;
                            locked_reg   <= 1'b1;
                            good_cnt_reg <= '0;
                        end else begin
                            good_cnt_reg <= good_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A misplaced or missing edge discards the slot in flight
                    if (frame_bad) begin
                        state_reg    <= ST_SYNCING;
                        locked_reg   <= 1'b0;
                        sync_err_reg <= 1'b1;
                        good_cnt_reg <= '0;
                    end else if (slot_end) begin
                        deliver_pend_reg <= 1'b1;
                        pend_slot_reg    <= SLOT_W'(bit_cnt_reg / SLOT_BITS);
                    end
                end
                default: begin
                    state_reg  <= ST_UNLOCKED;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_data   = sample_data_reg;
    assign bus.sample_slot   = sample_slot_reg;
    assign bus.sample_valid  = sample_valid_reg;
    assign bus.sample_toggle = sample_toggle_reg;
    assign bus.locked        = locked_reg;
    assign bus.sync_err      = sync_err_reg;

endmodule

// File: tb/tb_i2s_tdm_deframer.sv
// Directed bench for i2s_tdm_deframer: lock-up, delivery order/latency,
// short and missing frames, and mid-frame reset.
module tb_i2s_tdm_deframer;
    import i2s_tdm_deframer_pkg::*;

    logic i2s_bclk = 1'b0;
    logic sys_rst  = 1'b1;
    always #5 i2s_bclk = ~i2s_bclk;

    i2s_tdm_deframer_if #(.DATA_WIDTH(24), .NUM_SLOTS(16)) bus ();

    i2s_tdm_deframer #(
        .SLOT_WIDTH(32), .DATA_WIDTH(24), .NUM_SLOTS(16), .LOCK_FRAMES(2)
    ) dut (
        .i2s_bclk (i2s_bclk),
        .sys_rst  (sys_rst),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] slot_vals [16];
    logic        carry_bit;
    int          tick_no = 0;
    int          frame_start;
    logic [23:0] q_data [$];
    logic [3:0]  q_slot [$];
    int          q_tick [$];
    int          err_cnt = 0;
    int          err_tick = -1;
    int          tog_cnt = 0;
    int          lock_tick = -1;
    logic        prev_toggle = 1'b0;
    logic        prev_locked = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic fs, input logic d);
        @(negedge i2s_bclk);
        bus.i2s_fsync = fs;
        bus.i2s_data  = d;
        @(posedge i2s_bclk);
        tick_no++;
        #1;
        if (bus.sample_valid === 1'b1) begin
            q_data.push_back(bus.sample_data);
            q_slot.push_back(bus.sample_slot);
            q_tick.push_back(tick_no);
            $display("sample slot=%0d data=%h tick=%0d", bus.sample_slot, bus.sample_data, tick_no);
        end
        if (bus.sync_err === 1'b1) begin
            err_cnt++;
            err_tick = tick_no;
            $display("sync_err tick=%0d", tick_no);
        end
        if (bus.sample_toggle !== prev_toggle) tog_cnt++;
        prev_toggle = bus.sample_toggle;
        if (bus.locked === 1'b1 && prev_locked !== 1'b1) lock_tick = tick_no;
        prev_locked = bus.locked;
    endtask

    function automatic logic frame_bit(input int i);
        logic [31:0] w;
        w = slot_vals[i / 32];
        return w[31 - (i % 32)];
    endfunction

    // Tick 0 raises fsync and carries the previous frame's final bit (1-bit delay)
    task automatic send_frame(input int len);
        for (int t = 0; t < len; t++) begin
            tick((t < 32) ? 1'b1 : 1'b0, (t == 0) ? carry_bit : frame_bit(t - 1));
            if (t == 0) frame_start = tick_no;
        end
        carry_bit = frame_bit(len - 1);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_slot.delete();
        q_tick.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   32'(bus.sample_data), 32'h0);
        check({tag, "_slot"},   32'(bus.sample_slot), 32'h0);
        check({tag, "_valid"},  32'(bus.sample_valid), 32'h0);
        check({tag, "_toggle"}, 32'(bus.sample_toggle), 32'h0);
        check({tag, "_locked"}, 32'(bus.locked), 32'h0);
        check({tag, "_err"},    32'(bus.sync_err), 32'h0);
    endtask

    initial begin
        int s;
        bus.i2s_fsync = 1'b0;
        bus.i2s_data  = 1'b0;
        carry_bit     = 1'b0;
        for (int k = 0; k < 16; k++) slot_vals[k] = {24'(32'hA00000 + k), 8'h3C};

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check_all_zero("reset");
        @(negedge i2s_bclk);
        sys_rst = 1'b0;

        // Three clean frames: lock at the 2nd good edge, frame 3 delivers all slots
        send_frame(512);
        send_frame(512);
        check("unlocked_f2", 32'(bus.locked), 32'h0);
        check("no_samples_unlocked", 32'(q_data.size()), 32'd0);
        check("no_toggle_unlocked", 32'(tog_cnt), 32'd0);
        send_frame(512);
        s = frame_start;
        check("lock_tick", 32'(lock_tick), 32'(s));
        check("f3_count", 32'(q_data.size()), 32'd15);
        send_frame(512);
        s = frame_start;
        check("f4_count", 32'(q_data.size()), 32'd31);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("f3_data%0d", k), 32'(q_data[k]), 32'(32'hA00000 + k));
            check($sformatf("f3_slot%0d", k), 32'(q_slot[k]), 32'(k));
        end
        check("slot15_tick", 32'(q_tick[15]), 32'(s + 1));
        check("slot15_pair", slot_pair(32'(q_slot[15])), 32'd7);
        check("slot15_lr", 32'(slot_lr(32'(q_slot[15]))), 32'd1);
        check("toggle_count", 32'(tog_cnt), 32'd31);
        check("no_err_clean", 32'(err_cnt), 32'd0);

        // Low payload byte discarded, one-bclk latency after slot LSB
        clear_q();
        slot_vals[0] = 32'hFFFFFF5A;
        send_frame(512);
        s = frame_start;
        check("edge_last_slot", 32'(q_slot[0]), 32'd15);
        check("edge_last_tick", 32'(q_tick[0]), 32'(s + 1));
        check("trunc_data", 32'(q_data[1]), 32'h00FFFFFF);
        check("trunc_slot", 32'(q_slot[1]), 32'd0);
        check("trunc_latency", 32'(q_tick[1]), 32'(s + 33));
        check("locked_after_edge", 32'(bus.locked), 32'h1);
        slot_vals[0] = {24'hA00000, 8'h3C};

        // Short frame: edge at bit 300
        clear_q();
        err_cnt = 0;
        send_frame(300);
        send_frame(512);
        s = frame_start;
        check("short_err_cnt", 32'(err_cnt), 32'd1);
        check("short_err_tick", 32'(err_tick), 32'(s));
        check("short_unlocked", 32'(bus.locked), 32'h0);
        check("short_count", 32'(q_data.size()), 32'd10);
        check("short_last_slot", 32'(q_slot[9]), 32'd8);
        send_frame(512);
        check("short_resync_quiet", 32'(q_data.size()), 32'd10);
        check("short_still_unlocked", 32'(bus.locked), 32'h0);
        send_frame(512);
        s = frame_start;
        check("short_relock", 32'(bus.locked), 32'h1);
        check("short_relock_tick", 32'(lock_tick), 32'(s));

        // Missing edge: fsync low for 600 bclks
        clear_q();
        err_cnt = 0;
        send_frame(600);
        s = frame_start;
        check("ovf_err_cnt", 32'(err_cnt), 32'd1);
        check("ovf_err_tick", 32'(err_tick), 32'(s + 512));
        check("ovf_unlocked", 32'(bus.locked), 32'h0);
        check("ovf_count", 32'(q_data.size()), 32'd16);
        check("ovf_last_slot", 32'(q_slot[15]), 32'd14);
        send_frame(512);
        check("ovf_no_err_syncing", 32'(err_cnt), 32'd1);
        check("ovf_no_samples", 32'(q_data.size()), 32'd16);
        send_frame(512);
        send_frame(512);
        s = frame_start;
        check("ovf_relock_tick", 32'(lock_tick), 32'(s));

        // Reset at bit 100 of a locked frame
        send_frame(101);
        @(negedge i2s_bclk);
        sys_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        @(negedge i2s_bclk);
        sys_rst   = 1'b0;
        carry_bit = 1'b0;
        send_frame(512);
        send_frame(512);
        check("rst_needs_frames", 32'(bus.locked), 32'h0);
        send_frame(512);
        s = frame_start;
        check("rst_relock_tick", 32'(lock_tick), 32'(s));
        check("rst_relocked", 32'(bus.locked), 32'h1);
        tick(1'b1, carry_bit);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
